pc_branch_ctrl: RTL and testbench

PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

---
 rtl/pc_pkg.sv | 31 +++
 rtl/pc_branch_ctrl_br_cond.sv | 38 +++
 rtl/pc_branch_ctrl.sv | 102 ++++++++++
 tb/tb_pc_branch_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the PC / branch controller.
//   br_type_e : branch class encoding carried on br_type (codes 9..15 behave as NONE)
//   state_e   : controller FSM state (RUN fetches, WAIT resolves a branch)
//   INSTR_BYTES : fetch stride in bytes
package pc_pkg;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_type_e;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // True for the codes that need a resolve cycle; unassigned codes fall through as NONE.
  function automatic logic is_branch(input logic [3:0] t);
    return (t >= 4'd1) && (t <= 4'd8);
  endfunction

endpackage

// File: rtl/pc_branch_ctrl_br_cond.sv
// Taken decision for the branch held in the controller.
//   br_type        : held branch class
//   a_sign, b_sign : bit 31 of the ALU operands captured at issue
//   alu_c          : ALU result in the resolve cycle
//   alu_zero       : ALU zero flag (bit 0 only)
//   taken          : branch/jump redirects the PC
module br_cond
  import pc_pkg::*;
(
  input  br_type_e    br_type,
  input  logic        a_sign,
  input  logic        b_sign,
  input  logic [31:0] alu_c,
  input  logic        alu_zero,
  output logic        taken
);

  // Signed less-than from a subtract result: when operand signs differ the
  // subtraction may overflow, so the sign of A decides directly.
  logic lt;
  assign lt = (a_sign != b_sign) ? a_sign : alu_c[31];

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = alu_zero;
      BR_BNE:  taken = !alu_zero;
      BR_BLT:  taken = lt;
      BR_BGE:  taken = !lt;
      BR_BLTU: taken = alu_c[0];   // ALU produces set-less-than-unsigned
      BR_BGEU: taken = alu_c[0];   // ALU produces set-greater-equal-unsigned
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program counter and branch resolution controller.
// RUN fetches sequentially; a branch parks the PC and spends one WAIT cycle
// resolving against the registered ALU result, then redirects or falls through.
//   clk, rst      : clock, synchronous active-high reset
//   stall         : freeze fetch while in RUN
//   br_type, imm  : branch class and immediate of the instruction at rom_addr
//   a_sign,b_sign : operand sign bits of the issuing branch
//   alu_c,alu_zero: ALU result / zero flag, valid in the WAIT cycle
//   rom_addr      : current PC
//   fetch_en      : instruction at rom_addr issues this cycle
//   redirect      : taken branch pulse (WAIT only)
//   link_addr     : branch PC + 4 during WAIT, else 0
//   misalign      : taken target had nonzero low bits (WAIT only)
//   busy          : in WAIT
module pc_branch_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [3:0]  br_type,
  input  logic [31:0] imm,
  input  logic        a_sign,
  input  logic        b_sign,
  input  logic [31:0] alu_c,
  input  logic [7:0]  alu_zero,
  output logic [31:0] rom_addr,
  output logic        fetch_en,
  output logic        redirect,
  output logic [31:0] link_addr,
  output logic        misalign,
  output logic        busy
);

  state_e      state;
  logic [31:0] pc, h_pc, h_imm;
  br_type_e    h_type;
  logic        h_a, h_b;
  logic        taken, in_wait;
  logic [31:0] target, seq_pc;
  logic        unused_zero_hi;

  assign unused_zero_hi = ^alu_zero[7:1];

  br_cond u_cond (
    .br_type  (h_type),
    .a_sign   (h_a),
    .b_sign   (h_b),
    .alu_c    (alu_c),
    .alu_zero (alu_zero[0]),
    .taken    (taken)
  );

  assign seq_pc = h_pc + INSTR_BYTES;
  assign target = (h_type == BR_JALR) ? {alu_c[31:1], 1'b0} : h_pc + h_imm;

  // Reset masks the WAIT outputs so an aborted branch never pulses redirect.
  assign in_wait   = (state == S_WAIT) && !rst;
  assign rom_addr  = pc;
  assign fetch_en  = !stall && (rst || state == S_RUN);
  assign busy      = in_wait;
  assign redirect  = in_wait && taken;
  assign misalign  = in_wait && taken && (target[1:0] != 2'b00);
  assign link_addr = in_wait ? seq_pc : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_RUN;
      pc     <= RESET_PC;
      h_pc   <= 32'h0;
      h_imm  <= 32'h0;
      h_type <= BR_NONE;
      h_a    <= 1'b0;
      h_b    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (!stall) begin
            if (is_branch(br_type)) begin
              h_type <= br_type_e'(br_type);
              h_imm  <= imm;
              h_a    <= a_sign;
              h_b    <= b_sign;
              h_pc   <= pc;
              state  <= S_WAIT;
            end else begin
              pc <= pc + INSTR_BYTES;
            end
          end
        end
        S_WAIT: begin
          pc    <= taken ? {target[31:2], 2'b00} : seq_pc;
          state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed bench for pc_branch_ctrl: a behavioural model tracks the PC and the
// pending branch; a negedge process compares every output each cycle, and the
// stimulus sequence pins known addresses with literal expectations.
module tb_pc_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, a_sign, b_sign;
  logic [3:0]  br_type;
  logic [31:0] imm, alu_c;
  logic [7:0]  alu_zero;
  logic [31:0] rom_addr, link_addr;
  logic        fetch_en, redirect, misalign, busy;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  pc_branch_ctrl #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_type(br_type), .imm(imm),
    .a_sign(a_sign), .b_sign(b_sign), .alu_c(alu_c), .alu_zero(alu_zero),
    .rom_addr(rom_addr), .fetch_en(fetch_en), .redirect(redirect),
    .link_addr(link_addr), .misalign(misalign), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  bit          m_pend;
  int          m_type;
  logic [31:0] m_imm, m_bpc;
  logic        m_a, m_b;

  function automatic bit m_taken(int t, logic a, logic b, logic [31:0] c, logic z);
    bit lt = (a != b) ? a : c[31];
    case (t)
      1: return z;
      2: return !z;
      3: return lt;
      4: return !lt;
      5, 6: return c[0];
      7, 8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(int t, logic [31:0] bpc, logic [31:0] im, logic [31:0] c);
    if (t == 8) return c & 32'hFFFF_FFFE;
    return bpc + im;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_pend = 0; m_type = 0; m_imm = 0; m_bpc = 0; m_a = 0; m_b = 0;
    end else if (m_pend) begin
      if (m_taken(m_type, m_a, m_b, alu_c, alu_zero[0]))
        m_pc = m_target(m_type, m_bpc, m_imm, alu_c) & 32'hFFFF_FFFC;
      else
        m_pc = m_bpc + 32'd4;
      m_pend = 0;
    end else if (!stall) begin
      if (br_type >= 4'd1 && br_type <= 4'd8) begin
        m_pend = 1; m_type = int'(br_type); m_imm = imm; m_bpc = m_pc;
        m_a = a_sign; m_b = b_sign;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      logic        e_fetch, e_busy, e_red, e_mis, tk;
      logic [31:0] e_link, tg;
      e_fetch = !stall; e_busy = 0; e_red = 0; e_mis = 0; e_link = 0;
      if (!rst && m_pend) begin
        tk = m_taken(m_type, m_a, m_b, alu_c, alu_zero[0]);
        tg = m_target(m_type, m_bpc, m_imm, alu_c);
        e_fetch = 0; e_busy = 1; e_red = tk; e_mis = tk && (tg[1:0] != 0);
        e_link = m_bpc + 32'd4;
      end
      chk("rom_addr",  rom_addr,  m_pc);
      chk("fetch_en",  32'(fetch_en), 32'(e_fetch));
      chk("busy",      32'(busy),     32'(e_busy));
      chk("redirect",  32'(redirect), 32'(e_red));
      chk("misalign",  32'(misalign), 32'(e_mis));
      chk("link_addr", link_addr, e_link);
    end
  end

  // One cycle of stimulus, applied just after the rising edge; returns once
  // combinational outputs have settled so literal checks see this cycle.
  task automatic cyc(input logic r, input logic s, input logic [3:0] bt, input logic [31:0] im,
                     input logic a, input logic b, input logic [31:0] c, input logic z);
    @(posedge clk); #1;
    rst = r; stall = s; br_type = bt; imm = im; a_sign = a; b_sign = b;
    alu_c = c; alu_zero = {7'b1010101, z};
    #1;
  endtask

  task automatic run(input logic [3:0] bt, input logic [31:0] im);
    cyc(0, 0, bt, im, 0, 0, 32'h0, 0);
  endtask

  task automatic resolve(input logic s, input logic [31:0] c, input logic z);
    cyc(0, s, 4'd0, 32'h0, 0, 0, c, z);
  endtask

  initial begin
    rst = 1; stall = 0; br_type = 0; imm = 0; a_sign = 0; b_sign = 0; alu_c = 0; alu_zero = 0;
    @(posedge clk); #1;
    chk_on = 1;
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 0);
    chk("rst_rom", rom_addr, 32'h0);
    chk("rst_fetch", 32'(fetch_en), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // sequential fetch 0,4,8,12
    run(4'd0, 0); chk("seq0", rom_addr, 32'h0);
    run(4'd0, 0); chk("seq4", rom_addr, 32'h4);
    run(4'd0, 0); chk("seq8", rom_addr, 32'h8);
    chk("seq_fetch", 32'(fetch_en), 32'd1);
    // JAL at 0xC to 0x40
    run(4'd7, 32'h34); chk("jal_rom", rom_addr, 32'hC);
    resolve(0, 0, 0); chk("jal_red", 32'(redirect), 32'd1); chk("jal_link", link_addr, 32'h10);
    // BEQ at 0x40 imm 0x20, zero=1
    run(4'd1, 32'h20); chk("beq_pc", rom_addr, 32'h40);
    resolve(0, 0, 1);
    chk("beq_busy", 32'(busy), 32'd1); chk("beq_red", 32'(redirect), 32'd1);
    chk("beq_link", link_addr, 32'h44);
    // back to 0x40
    run(4'd7, 32'hFFFF_FFE0); chk("beq_tgt", rom_addr, 32'h60);
    resolve(0, 0, 0);
    // BLT signs differ, a negative -> taken
    cyc(0, 0, 4'd3, 32'h100, 1, 0, 0, 0); chk("blt_pc", rom_addr, 32'h40);
    resolve(0, 32'h7FFF_FFFF, 0); chk("blt_red", 32'(redirect), 32'd1);
    run(4'd7, 32'hFFFF_FF00); chk("blt_tgt", rom_addr, 32'h140);
    resolve(0, 0, 0);
    // BLT same sign, c[31]=0 -> not taken
    cyc(0, 0, 4'd3, 32'h100, 0, 0, 0, 0); chk("blt2_pc", rom_addr, 32'h40);
    resolve(0, 32'h0000_0005, 0); chk("blt2_red", 32'(redirect), 32'd0);
    // back-to-back: BNE issues in the first RUN cycle; zero=1 -> not taken
    run(4'd2, 32'h8); chk("bnt_pc", rom_addr, 32'h44);
    resolve(0, 0, 1);
    run(4'd6, 32'h10); chk("bgeu_pc", rom_addr, 32'h48);
    resolve(0, 32'h1, 0);
    run(4'd5, 32'h8); chk("bltu_pc", rom_addr, 32'h58);
    resolve(0, 32'h0, 0);
    cyc(0, 0, 4'd4, 32'h4, 0, 1, 0, 0); chk("bge_pc", rom_addr, 32'h5C);
    resolve(0, 32'h8000_0000, 0); chk("bge_red", 32'(redirect), 32'd1);
    // JAL to 0x10, then JALR with misaligned target
    run(4'd7, 32'hFFFF_FFB0); chk("bge_tgt", rom_addr, 32'h60);
    resolve(0, 0, 0);
    run(4'd8, 32'h0); chk("jalr_pc", rom_addr, 32'h10);
    resolve(0, 32'h0000_0103, 0);
    chk("jalr_mis", 32'(misalign), 32'd1); chk("jalr_link", link_addr, 32'h14);
    // JAL to 0xFFFF_FFFC, then wrap
    run(4'd7, 32'hFFFF_FEFC); chk("jalr_tgt", rom_addr, 32'h100);
    resolve(0, 0, 0);
    run(4'd0, 0); chk("wrap_pc", rom_addr, 32'hFFFF_FFFC);
    cyc(0, 1, 4'd7, 32'h40, 0, 0, 0, 0); chk("wrap0", rom_addr, 32'h0);
    chk("stall_fetch", 32'(fetch_en), 32'd0);
    cyc(0, 1, 4'd7, 32'h40, 0, 0, 0, 0);
    run(4'd1, 32'h40); chk("stall_hold", rom_addr, 32'h0);
    resolve(1, 0, 1); chk("wait_stall_red", 32'(redirect), 32'd1);
    // code 9 acts as NONE
    run(4'd9, 32'h100); chk("c9_pc", rom_addr, 32'h40);
    run(4'd2, 32'h10); chk("c9_next", rom_addr, 32'h44);
    // reset during taken BNE's WAIT
    cyc(1, 0, 4'd0, 0, 0, 0, 0, 0);
    chk("rstw_red", 32'(redirect), 32'd0); chk("rstw_busy", 32'(busy), 32'd0);
    run(4'd0, 0); chk("rstw_pc", rom_addr, 32'h0); chk("rstw_busy2", 32'(busy), 32'd0);
    run(4'd0, 0); chk("rstw_seq", rom_addr, 32'h4);
    @(posedge clk); #1;
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
